// File: rtl/enc_pkg.sv
// Shared definitions for the 16-to-4 request encoder.
//   N_REQ  : number of request lines
//   IDX_W  : width of an index into the request lines
//   idx_t  : index type
//   onehot : converts an index to a one-hot request vector
package enc_pkg;

    localparam int N_REQ = 16;
    localparam int IDX_W = $clog2(N_REQ);

    typedef logic [IDX_W-1:0] idx_t;

    function automatic logic [N_REQ-1:0] onehot(input idx_t idx);
        logic [N_REQ-1:0] vec;
        vec      = '0;
        vec[idx] = 1'b1;
        return vec;
    endfunction

endpackage

// File: rtl/priority_enc_16x4.sv
// Combinational fixed-priority encoder; bit 15 has the highest priority.
//   vec : input vector
//   idx : index of the highest set bit (0 when vec is zero)
//   any : at least one bit of vec is set
module priority_enc_16x4
    import enc_pkg::*;
(
    input  logic [N_REQ-1:0] vec,
    output idx_t             idx,
    output logic             any
);

    // Ascending scan: the last set bit seen (the highest) wins.
    always_comb begin
        idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (vec[i]) begin
                idx = idx_t'(i);
            end
        end
    end

    assign any = |vec;

endmodule

// File: rtl/req_encoder_16x4.sv
// Buffered 16-to-4 priority encoder. One-cycle request pulses are collected
// in a sticky pending register and serialized as a stream of indices, highest
// index first, one per valid/ready handshake.
//   clk         : rising-edge clock
//   rst_n       : asynchronous active-low reset
//   req_in      : request pulses, bit i requests index i
//   en          : capture enable for req_in
//   ready_in    : downstream accepts y_out this cycle
//   y_out       : presented index
//   valid_out   : y_out is valid
//   pending_out : pending register, including the presented bit
//   pend_cnt    : popcount of pending_out
module req_encoder_16x4
    import enc_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req_in,
    input  logic             en,
    input  logic             ready_in,
    output idx_t             y_out,
    output logic             valid_out,
    output logic [N_REQ-1:0] pending_out,
    output logic [IDX_W:0]   pend_cnt
);

    logic [N_REQ-1:0] pending;
    logic [N_REQ-1:0] clr;
    logic [N_REQ-1:0] set;
    logic [N_REQ-1:0] cand;
    logic             acc;
    logic             slot_free;
    idx_t             cand_idx;
    logic             cand_any;

    assign acc       = valid_out & ready_in;
    assign clr       = acc ? onehot(y_out) : '0;
    assign set       = en ? req_in : '0;
    // Only bits already registered compete for the slot; this cycle's
    // captures become visible one edge later.
    assign cand      = pending & ~clr;
    assign slot_free = ~valid_out | acc;

    priority_enc_16x4 u_prio (
        .vec (cand),
        .idx (cand_idx),
        .any (cand_any)
    );

    // Set is OR-ed after the clear so a bit re-requested in its own accept
    // cycle stays pending.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
        end else begin
            pending <= cand | set;
        end
    end

    // The presented index is held under backpressure; no preemption.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_out     <= '0;
            valid_out <= 1'b0;
        end else if (slot_free) begin
            if (cand_any) begin
                y_out     <= cand_idx;
                valid_out <= 1'b1;
            end else begin
                valid_out <= 1'b0;
            end
        end
    end

    always_comb begin
        pend_cnt = '0;
        for (int i = 0; i < N_REQ; i++) begin
            pend_cnt = pend_cnt + {{IDX_W{1'b0}}, pending[i]};
        end
    end

    assign pending_out = pending;

endmodule

// File: tb/tb_req_encoder_16x4.sv
module tb_req_encoder_16x4;

    logic        clk;
    logic        rst_n;
    logic [15:0] req_in;
    logic        en;
    logic        ready_in;
    logic [3:0]  y_out;
    logic        valid_out;
    logic [15:0] pending_out;
    logic [4:0]  pend_cnt;

    int vectors;
    int miscompares;

    // Reference model state: a set of pending line numbers and a presented slot.
    bit          m_pend [16];
    bit          m_valid;
    int          m_y;

    typedef struct {
        logic [15:0] req;
        logic        en;
        logic        rdy;
        logic        ev;
        int          ey;
        int          ec;
    } vec_t;

    vec_t table_q[$];

    req_encoder_16x4 dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_in      (req_in),
        .en          (en),
        .ready_in    (ready_in),
        .y_out       (y_out),
        .valid_out   (valid_out),
        .pending_out (pending_out),
        .pend_cnt    (pend_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    function automatic int model_cnt();
        int n = 0;
        foreach (m_pend[i]) n += int'(m_pend[i]);
        return n;
    endfunction

    function automatic logic [15:0] model_vec();
        logic [15:0] v = '0;
        foreach (m_pend[i]) v[i] = m_pend[i];
        return v;
    endfunction

    task automatic model_reset();
        foreach (m_pend[i]) m_pend[i] = 1'b0;
        m_valid = 1'b0;
        m_y     = 0;
    endtask

    // One clock edge of the reference behaviour.
    task automatic model_edge(input logic [15:0] r, input logic e, input logic rd);
        bit accepted;
        bit found;
        accepted = m_valid && rd;
        if (accepted) m_pend[m_y] = 1'b0;
        if (!m_valid || accepted) begin
            found = 1'b0;
            for (int k = 15; k >= 0 && !found; k--) begin
                if (m_pend[k]) begin
                    found = 1'b1;
                    m_y   = k;
                end
            end
            m_valid = found;
        end
        if (e) begin
            for (int k = 0; k < 16; k++) begin
                if (r[k]) m_pend[k] = 1'b1;
            end
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".valid"},   int'(valid_out),   int'(m_valid));
        chk({tag, ".y"},       int'(y_out),       m_y);
        chk({tag, ".pending"}, int'(pending_out), int'(model_vec()));
        chk({tag, ".cnt"},     int'(pend_cnt),    model_cnt());
    endtask

    // Drive inputs, take one edge, then sample 1 time unit later.
    task automatic step(input logic [15:0] r, input logic e, input logic rd,
                        input string tag);
        req_in   = r;
        en       = e;
        ready_in = rd;
        @(posedge clk);
        model_edge(r, e, rd);
        #1;
        check_model(tag);
    endtask

    initial begin
        vec_t v;
        vectors     = 0;
        miscompares = 0;
        rst_n    = 1'b0;
        req_in   = '0;
        en       = 1'b0;
        ready_in = 1'b0;
        model_reset();

        // Single pulse on line 5.
        table_q.push_back('{16'h0020, 1'b1, 1'b1, 1'b0, 0, 1});
        table_q.push_back('{16'h0000, 1'b1, 1'b1, 1'b1, 5, 1});
        table_q.push_back('{16'h0000, 1'b1, 1'b1, 1'b0, 5, 0});
        // Ordering 15, 8, 0.
        table_q.push_back('{16'h8101, 1'b1, 1'b1, 1'b0, 5, 3});
        table_q.push_back('{16'h0000, 1'b1, 1'b1, 1'b1, 15, 3});
        table_q.push_back('{16'h0000, 1'b1, 1'b1, 1'b1, 8, 2});
        table_q.push_back('{16'h0000, 1'b1, 1'b1, 1'b1, 0, 1});
        table_q.push_back('{16'h0000, 1'b1, 1'b1, 1'b0, 0, 0});
        // Enable gating, then all 16 lines at once.
        for (int k = 0; k < 5; k++)
            table_q.push_back('{16'hFFFF, 1'b0, 1'b1, 1'b0, 0, 0});
        table_q.push_back('{16'hFFFF, 1'b1, 1'b1, 1'b0, 0, 16});
        for (int k = 0; k < 16; k++)
            table_q.push_back('{16'h0000, 1'b1, 1'b1, 1'b1, 15 - k, 16 - k});
        table_q.push_back('{16'h0000, 1'b1, 1'b1, 1'b0, 0, 0});

        repeat (2) @(posedge clk);
        #1;
        chk("reset.valid",   int'(valid_out),   0);
        chk("reset.y",       int'(y_out),       0);
        chk("reset.pending", int'(pending_out), 0);
        chk("reset.cnt",     int'(pend_cnt),    0);
        rst_n = 1'b1;

        // Table-driven sequences.
        for (int i = 0; i < table_q.size(); i++) begin
            v = table_q[i];
            step(v.req, v.en, v.rdy, $sformatf("tbl%0d", i));
            chk($sformatf("tbl%0d.exp_valid", i), int'(valid_out), int'(v.ev));
            chk($sformatf("tbl%0d.exp_y", i),     int'(y_out),     v.ey);
            chk($sformatf("tbl%0d.exp_cnt", i),   int'(pend_cnt),  v.ec);
        end

        // Backpressure: index 2 held while 14 arrives, no preemption.
        step(16'h0004, 1'b1, 1'b0, "bp0");
        step(16'h0000, 1'b1, 1'b0, "bp1");
        step(16'h0000, 1'b1, 1'b0, "bp2");
        step(16'h4000, 1'b1, 1'b0, "bp3");
        step(16'h0000, 1'b1, 1'b0, "bp4");
        chk("bp.hold_y",     int'(y_out),     2);
        chk("bp.hold_valid", int'(valid_out), 1);
        chk("bp.hold_cnt",   int'(pend_cnt),  2);
        step(16'h0000, 1'b1, 1'b1, "bp5");
        chk("bp.next_y",     int'(y_out),     14);
        chk("bp.next_valid", int'(valid_out), 1);
        step(16'h0000, 1'b1, 1'b1, "bp6");
        chk("bp.drained", int'(valid_out), 0);

        // Set wins over clear on line 3.
        step(16'h0008, 1'b1, 1'b0, "sw0");
        step(16'h0000, 1'b1, 1'b0, "sw1");
        chk("sw.presented", int'(y_out), 3);
        step(16'h0008, 1'b1, 1'b1, "sw2");
        chk("sw.still_pending", int'(pending_out[3]), 1);
        step(16'h0000, 1'b1, 1'b1, "sw3");
        chk("sw.represented_y",     int'(y_out),     3);
        chk("sw.represented_valid", int'(valid_out), 1);
        step(16'h0000, 1'b1, 1'b1, "sw4");

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            logic [15:0] r;
            r = 16'($urandom) & 16'($urandom) & 16'($urandom);
            step(r, ($urandom_range(0, 4) != 0), ($urandom_range(0, 2) != 0),
                 $sformatf("rnd%0d", i));
        end

        // Asynchronous reset mid-cycle with every line pending.
        step(16'hFFFF, 1'b1, 1'b0, "ar0");
        step(16'h0000, 1'b1, 1'b0, "ar1");
        chk("ar.full", int'(pend_cnt), 16);
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("ar.valid",   int'(valid_out),   0);
        chk("ar.y",       int'(y_out),       0);
        chk("ar.pending", int'(pending_out), 0);
        chk("ar.cnt",     int'(pend_cnt),    0);
        rst_n = 1'b1;
        step(16'h0002, 1'b1, 1'b1, "post0");
        step(16'h0000, 1'b1, 1'b1, "post1");
        chk("post.y", int'(y_out), 1);
        step(16'h0000, 1'b1, 1'b1, "post2");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
